// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: merges single-cycle A results with FIFO-buffered
// multi-cycle B results onto one write port and tracks pending B destinations.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  qAddrA,
  input  logic [4:0]  qAddrB,
  output logic        busyA,
  output logic        busyB,
  output logic        write,
  output logic [4:0]  wrAddr,
  output logic [31:0] wrData
);

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned PTR_W   = 2;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned STARVE_W = 3;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NREGS   = 32;

  logic [REG_W-1:0]    fifo_rd   [DEPTH];
  logic [DATA_W-1:0]   fifo_data [DEPTH];
  logic [PTR_W-1:0]    wptr, rptr;
  logic [CNT_W-1:0]    count;
  logic [STARVE_W-1:0] starve_cnt;
  logic [NREGS-1:0]    pend, pend_next;
  logic                wr_b;

  logic fifo_nempty, starve, sel_a, sel_b, push, pop;
  logic [REG_W-1:0]  head_rd;
  logic [DATA_W-1:0] head_data;

  // Arbitration: a starved B head beats A, otherwise A wins, otherwise drain B.
  always_comb begin
    fifo_nempty = (count != CNT_W'(0));
    starve      = (starve_cnt == STARVE_W'(7)) && fifo_nempty;
    sel_b       = fifo_nempty && (starve || !a_valid);
    sel_a       = a_valid && !starve;
    push        = b_valid && b_ready;
    pop         = sel_b;
    head_rd     = fifo_rd[rptr];
    head_data   = fifo_data[rptr];
  end

  assign a_ready = !starve;
  assign b_ready = (count != CNT_W'(DEPTH));

  // Buffered payload needs no reset; pointers/count make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wptr]   <= b_rd;
      fifo_data[wptr] <= b_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Counts consecutive A grants while B waits; saturates so the B head is forced out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!fifo_nempty || sel_b) begin
      starve_cnt <= '0;
    end else if (sel_a && (starve_cnt != STARVE_W'(7))) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write  <= 1'b0;
      wr_b   <= 1'b0;
      wrAddr <= '0;
      wrData <= '0;
    end else if (sel_b) begin
      write  <= (head_rd != REG_W'(0));
      wr_b   <= 1'b1;
      wrAddr <= head_rd;
      wrData <= head_data;
    end else if (sel_a) begin
      write  <= (a_rd != REG_W'(0));
      wr_b   <= 1'b0;
      wrAddr <= a_rd;
      wrData <= a_data;
    end else begin
      write  <= 1'b0;
      wr_b   <= 1'b0;
    end
  end

  // Retire the outgoing B write first so a same-edge issue to that register wins.
  always_comb begin
    pend_next = pend;
    if (write && wr_b) pend_next[wrAddr] = 1'b0;
    if (iss_valid && (iss_rd != REG_W'(0))) pend_next[iss_rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= pend_next;
  end

  assign busyA = pend[qAddrA] | (write & wr_b & (wrAddr == qAddrA) & (qAddrA != REG_W'(0)));
  assign busyB = pend[qAddrB] | (write & wr_b & (wrAddr == qAddrB) & (qAddrB != REG_W'(0)));

endmodule
